// File: rtl/lcd_frame_sequencer_if.sv
// Signal bundle between the enable control / horizontal timing generator and the
// vertical timing and panel power sequencer.
interface lcd_frame_sequencer_if;
    logic       enable;
    logic       line_end;
    logic       timing_run;
    logic [9:0] VsyncCount;
    logic       Vsync;
    logic       vDE;
    logic       frame_start;
    logic       disp_on;
    logic       bl_en;
    logic       ready;

    modport master (
        output enable, line_end,
        input  timing_run, VsyncCount, Vsync, vDE, frame_start, disp_on, bl_en, ready
    );

    modport slave (
        input  enable, line_end,
        output timing_run, VsyncCount, Vsync, vDE, frame_start, disp_on, bl_en, ready
    );
endinterface

// File: rtl/lcd_frame_sequencer.sv
// Vertical line counter (Vsync, vDE, frame_start) and panel power sequencer for the
// 480x272 TFT. All flops update on the falling edge of the pixel clock.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_OFF     | panel off, timing stopped, waits for enable
// S_STARTUP | timing running, waiting PWR_FRAMES frames before DISP
// S_DISP    | DISP high, waiting BL_FRAMES frames before backlight
// S_RUN     | backlight on, panel ready
// S_BL_OFF  | backlight off, DISP held for OFF_FRAMES frames
// S_DSP_OFF | DISP low, timing kept running for one more frame
module lcd_frame_sequencer #(
    parameter int V_TOTAL    = 286,
    parameter int V_SYNC     = 10,
    parameter int V_DE_START = 12,
    parameter int V_ACTIVE   = 272,
    parameter int PWR_FRAMES = 4,
    parameter int BL_FRAMES  = 2,
    parameter int OFF_FRAMES = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    lcd_frame_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_OFF,
        S_STARTUP,
        S_DISP,
        S_RUN,
        S_BL_OFF,
        S_DSP_OFF
    } state_t;

    localparam logic [9:0] LINE_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] SYNC_END  = 10'(V_SYNC);
    localparam logic [9:0] DE_FIRST  = 10'(V_DE_START);
    localparam logic [9:0] DE_END    = 10'(V_DE_START + V_ACTIVE);
    localparam logic [7:0] PWR_LAST  = 8'(PWR_FRAMES - 1);
    localparam logic [7:0] BL_LAST   = 8'(BL_FRAMES - 1);
    localparam logic [7:0] OFF_LAST  = 8'(OFF_FRAMES - 1);

    state_t     state, state_nxt;
    logic [7:0] frm_cnt;
    logic [9:0] line_cnt;
    logic       timing_run, vsync_q, frame_start, disp_on, bl_en, ready;
    logic       run_nxt, disp_nxt, bl_nxt, rdy_nxt;

    // Line counter, sync and frame marker; all derived from the current run level.
    always_ff @(negedge clk or negedge rstn) begin
        if (!rstn) begin
            line_cnt    <= '0;
            vsync_q     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            vsync_q     <= timing_run & (line_cnt >= SYNC_END);
            frame_start <= timing_run & bus.line_end & (line_cnt == LINE_LAST);
            if (!timing_run) begin
                line_cnt <= '0;
            end else if (bus.line_end) begin
                line_cnt <= (line_cnt == LINE_LAST) ? '0 : line_cnt + 10'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_OFF: begin
                if (bus.enable) state_nxt = S_STARTUP;
            end
            S_STARTUP: begin
                if (!bus.enable)                               state_nxt = S_OFF;
                else if (frame_start && (frm_cnt == PWR_LAST)) state_nxt = S_DISP;
            end
            S_DISP: begin
                if (!bus.enable)                              state_nxt = S_BL_OFF;
                else if (frame_start && (frm_cnt == BL_LAST)) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (!bus.enable) state_nxt = S_BL_OFF;
            end
            // Shutdown always runs to completion; enable is not looked at here.
            S_BL_OFF: begin
                if (frame_start && (frm_cnt == OFF_LAST)) state_nxt = S_DSP_OFF;
            end
            S_DSP_OFF: begin
                if (frame_start) state_nxt = S_OFF;
            end
            default: state_nxt = S_OFF;
        endcase

        run_nxt  = (state_nxt != S_OFF);
        disp_nxt = (state_nxt == S_DISP) || (state_nxt == S_RUN) || (state_nxt == S_BL_OFF);
        bl_nxt   = (state_nxt == S_RUN);
        rdy_nxt  = (state_nxt == S_RUN);
    end

    // Outputs are registered from the next state so they move on the transition edge.
    always_ff @(negedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_OFF;
            frm_cnt    <= '0;
            timing_run <= 1'b0;
            disp_on    <= 1'b0;
            bl_en      <= 1'b0;
            ready      <= 1'b0;
        end else begin
            state      <= state_nxt;
            timing_run <= run_nxt;
            disp_on    <= disp_nxt;
            bl_en      <= bl_nxt;
            ready      <= rdy_nxt;
            if (state_nxt != state) begin
                frm_cnt <= '0;
            end else if (frame_start) begin
                frm_cnt <= frm_cnt + 8'd1;
            end
        end
    end

    assign bus.timing_run  = timing_run;
    assign bus.VsyncCount  = line_cnt;
    assign bus.Vsync       = vsync_q;
    assign bus.vDE         = timing_run & (line_cnt >= DE_FIRST) & (line_cnt < DE_END);
    assign bus.frame_start = frame_start;
    assign bus.disp_on     = disp_on;
    assign bus.bl_en       = bl_en;
    assign bus.ready       = ready;

endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// Self-checking bench for lcd_frame_sequencer: vector table, hand-written power
// sequences and a randomized run against a phase-table reference model.
module tb_lcd_frame_sequencer;

    localparam int V_TOTAL    = 286;
    localparam int V_SYNC     = 10;
    localparam int V_DE_START = 12;
    localparam int V_ACTIVE   = 272;
    localparam int PWR        = 2;
    localparam int BL         = 1;
    localparam int OFF        = 2;

    logic clk;
    logic rstn;

    lcd_frame_sequencer_if bus ();

    lcd_frame_sequencer #(
        .V_TOTAL    (V_TOTAL),
        .V_SYNC     (V_SYNC),
        .V_DE_START (V_DE_START),
        .V_ACTIVE   (V_ACTIVE),
        .PWR_FRAMES (PWR),
        .BL_FRAMES  (BL),
        .OFF_FRAMES (OFF)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Vector record: inputs for one cycle and the outputs expected after that edge.
    typedef struct {
        bit en; bit le;
        bit run; int cnt; bit vs; bit vde; bit fs; bit disp; bit bl; bit rdy;
    } vec_t;
    vec_t vt[8];

    // Power phases described by what they drive and how they are left.
    typedef struct {
        bit run; bit disp; bit bl; bit rdy;
        int frames;       // frame pulses needed to leave, 0 = never by frames
        int after_frames; // phase entered when the frames have elapsed
        int on_disable;   // phase entered when enable drops, -1 = ignored
    } phase_t;
    phase_t ph_tbl[6];

    bit m_run, m_vs, m_fs, m_disp, m_bl, m_rdy;
    int m_cnt, m_ph, m_pfr;

    int fs_n, disp_at, bl_at, rdy_at, dfall, rfall, bl_seen, disp_seen;
    int fs_at[4];
    int t1, t2;
    bit en_r, le_r;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tmo(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    // Inputs change just after the rising edge; the DUT acts on the falling edge;
    // outputs are observed at the following rising edge.
    task automatic cyc(input bit en, input bit le);
        bus.enable   = en;
        bus.line_end = le;
        @(negedge clk);
        @(posedge clk);
    endtask

    function automatic int dut_vec();
        int v;
        v = 0;
        v[16:0] = {bus.timing_run, bus.VsyncCount, bus.Vsync, bus.vDE,
                   bus.frame_start, bus.disp_on, bus.bl_en, bus.ready};
        return v;
    endfunction

    function automatic int pack_vec(input bit run, input int cnt, input bit vs, input bit vde,
                                    input bit fs, input bit disp, input bit bl, input bit rdy);
        int v;
        logic [9:0] c;
        c = 10'(cnt);
        v = 0;
        v[16:0] = {run, c, vs, vde, fs, disp, bl, rdy};
        return v;
    endfunction

    task automatic model_reset();
        m_run = 0; m_vs = 0; m_fs = 0; m_disp = 0; m_bl = 0; m_rdy = 0;
        m_cnt = 0; m_ph = 0; m_pfr = 0;
    endtask

    task automatic model_step(input bit en, input bit le);
        int  nph;
        bit  fs_now;
        fs_now = m_run && le && (m_cnt == V_TOTAL - 1);
        m_vs   = m_run && (m_cnt >= V_SYNC);
        if (!m_run)  m_cnt = 0;
        else if (le) m_cnt = (m_cnt + 1) % V_TOTAL;
        nph = m_ph;
        if (m_ph == 0) begin
            if (en) nph = 1;
        end else if (!en && ph_tbl[m_ph].on_disable >= 0) begin
            nph = ph_tbl[m_ph].on_disable;
        end else if (m_fs && ph_tbl[m_ph].frames > 0 && m_pfr + 1 == ph_tbl[m_ph].frames) begin
            nph = ph_tbl[m_ph].after_frames;
        end
        if (nph != m_ph) m_pfr = 0;
        else if (m_fs)   m_pfr++;
        m_ph   = nph;
        m_fs   = fs_now;
        m_run  = ph_tbl[nph].run;
        m_disp = ph_tbl[nph].disp;
        m_bl   = ph_tbl[nph].bl;
        m_rdy  = ph_tbl[nph].rdy;
    endtask

    function automatic bit model_vde();
        return m_run && (m_cnt >= V_DE_START) && (m_cnt < V_DE_START + V_ACTIVE);
    endfunction

    task automatic do_reset();
        rstn         = 1'b0;
        bus.enable   = 1'b0;
        bus.line_end = 1'b0;
        repeat (2) @(posedge clk);
        rstn = 1'b1;
        model_reset();
    endtask

    task automatic advance_to(input int n);
        int k;
        k = 0;
        while (bus.VsyncCount != 10'(n) && k < 400) begin
            cyc(1'b1, 1'b1);
            k++;
        end
        if (k >= 400) tmo($sformatf("advance_to_%0d", n));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // run, disp, bl, rdy, frames, after_frames, on_disable
        ph_tbl[0] = '{0, 0, 0, 0, 0,   0, -1}; // off
        ph_tbl[1] = '{1, 0, 0, 0, PWR, 2,  0}; // startup
        ph_tbl[2] = '{1, 1, 0, 0, BL,  3,  4}; // disp
        ph_tbl[3] = '{1, 1, 1, 1, 0,   3,  4}; // run
        ph_tbl[4] = '{1, 1, 0, 0, OFF, 5, -1}; // backlight off
        ph_tbl[5] = '{1, 0, 0, 0, 1,   0, -1}; // disp off

        // en, le, run, cnt, vs, vde, fs, disp, bl, rdy
        vt[0] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[1] = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0}; // run starts, line_end ignored this edge
        vt[2] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
        vt[3] = '{1, 0, 1, 1, 0, 0, 0, 0, 0, 0};
        vt[4] = '{1, 1, 1, 2, 0, 0, 0, 0, 0, 0};
        vt[5] = '{0, 1, 0, 3, 0, 0, 0, 0, 0, 0}; // stop: last count still taken
        vt[6] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0}; // forced to 0
        vt[7] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

        // Reset state and vector table
        do_reset();
        chk("reset_outputs", dut_vec(), 0);
        for (int i = 0; i < 8; i++) begin
            cyc(vt[i].en, vt[i].le);
            chk($sformatf("vec%0d", i), dut_vec(),
                pack_vec(vt[i].run, vt[i].cnt, vt[i].vs, vt[i].vde,
                         vt[i].fs, vt[i].disp, vt[i].bl, vt[i].rdy));
        end

        // Vsync / vDE boundaries and line wrap
        do_reset();
        cyc(1'b1, 1'b0);
        advance_to(9);
        chk("vsync_line9", int'(bus.Vsync), 0);
        cyc(1'b1, 1'b0);
        chk("vsync_line9_hold", int'(bus.Vsync), 0);
        cyc(1'b1, 1'b1);
        chk("line10_count", int'(bus.VsyncCount), 10);
        chk("vsync_line10_lag", int'(bus.Vsync), 0);
        cyc(1'b1, 1'b0);
        chk("vsync_line10", int'(bus.Vsync), 1);
        advance_to(11);
        chk("vde_line11", int'(bus.vDE), 0);
        cyc(1'b1, 1'b1);
        chk("vde_line12", int'(bus.vDE), 1);
        advance_to(283);
        chk("vde_line283", int'(bus.vDE), 1);
        cyc(1'b1, 1'b1);
        chk("vde_line284", int'(bus.vDE), 0);
        advance_to(285);
        chk("no_fs_at_285", int'(bus.frame_start), 0);
        cyc(1'b1, 1'b1);
        chk("wrap_count", int'(bus.VsyncCount), 0);
        chk("wrap_fs", int'(bus.frame_start), 1);
        cyc(1'b1, 1'b0);
        chk("fs_one_clk", int'(bus.frame_start), 0);

        // Frame period with line_end every 4 clocks
        t1 = -1; t2 = -1;
        for (int i = 0; i < 3000 && t2 < 0; i++) begin
            cyc(1'b1, (i % 4) == 3);
            if (bus.frame_start) begin
                if (t1 < 0) t1 = i;
                else        t2 = i;
            end
        end
        if (t2 < 0) tmo("frame_period");
        else        chk("frame_period", t2 - t1, V_TOTAL * 4);

        // Power-up: disp_on after the 2nd frame_start, bl_en/ready after the 3rd
        do_reset();
        fs_n = 0; disp_at = -1; bl_at = -1; rdy_at = -1;
        for (int k = 0; k < 4; k++) fs_at[k] = -100;
        for (int i = 0; i < 1500 && bl_at < 0; i++) begin
            cyc(1'b1, 1'b1);
            if (bus.frame_start) begin
                fs_n++;
                if (fs_n <= 3) fs_at[fs_n] = i;
            end
            if (bus.disp_on && disp_at < 0) disp_at = i;
            if (bus.bl_en   && bl_at   < 0) bl_at   = i;
            if (bus.ready   && rdy_at  < 0) rdy_at  = i;
        end
        if (bl_at < 0) begin
            tmo("powerup");
        end else begin
            chk("disp_on_rise", disp_at, fs_at[2] + 1);
            chk("bl_en_rise",   bl_at,   fs_at[3] + 1);
            chk("ready_rise",   rdy_at,  fs_at[3] + 1);
        end

        // Power-down from RUN, with an ignored enable pulse during shutdown
        cyc(1'b0, 1'b1);
        chk("bl_off_next_edge", int'(bus.bl_en), 0);
        chk("ready_off_next_edge", int'(bus.ready), 0);
        chk("disp_held", int'(bus.disp_on), 1);
        fs_n = 0; dfall = -1; rfall = -1; bl_seen = 0;
        for (int k = 0; k < 4; k++) fs_at[k] = -100;
        for (int j = 1; j < 2000 && rfall < 0; j++) begin
            cyc((j >= 5) && (j < 100), 1'b1);
            if (bus.frame_start) begin
                fs_n++;
                if (fs_n <= 3) fs_at[fs_n] = j;
            end
            if (!bus.disp_on    && dfall < 0) dfall = j;
            if (!bus.timing_run && rfall < 0) rfall = j;
            if (bus.bl_en) bl_seen++;
        end
        if (rfall < 0) begin
            tmo("powerdown");
        end else begin
            chk("disp_on_fall",    dfall,   fs_at[2] + 1);
            chk("timing_run_fall", rfall,   fs_at[3] + 1);
            chk("bl_stays_off",    bl_seen, 0);
            cyc(1'b0, 1'b1);
            chk("count_cleared_after_off", int'(bus.VsyncCount), 0);
        end

        // Abort during STARTUP in the same clk as the frame pulse that would advance it
        do_reset();
        cyc(1'b1, 1'b0);
        fs_n = 0; disp_seen = 0;
        for (int i = 0; i < 1000 && fs_n < PWR; i++) begin
            cyc(1'b1, 1'b1);
            if (bus.frame_start) fs_n++;
            if (bus.disp_on) disp_seen++;
        end
        if (fs_n < PWR) begin
            tmo("startup_abort");
        end else begin
            cyc(1'b0, 1'b1);
            chk("abort_run_off", int'(bus.timing_run), 0);
            chk("abort_disp_off", int'(bus.disp_on), 0);
            chk("abort_disp_never", disp_seen, 0);
            cyc(1'b0, 1'b0);
            chk("abort_count_zero", int'(bus.VsyncCount), 0);
        end

        // Asynchronous reset mid-frame while in RUN
        do_reset();
        rdy_at = -1;
        for (int i = 0; i < 1500 && rdy_at < 0; i++) begin
            cyc(1'b1, 1'b1);
            if (bus.ready) rdy_at = i;
        end
        if (rdy_at < 0) begin
            tmo("reach_run");
        end else begin
            repeat (100) cyc(1'b1, 1'b1);
            #2 rstn = 1'b0;
            #1;
            chk("rst_bl_en",      int'(bus.bl_en), 0);
            chk("rst_disp_on",    int'(bus.disp_on), 0);
            chk("rst_timing_run", int'(bus.timing_run), 0);
            chk("rst_count",      int'(bus.VsyncCount), 0);
            chk("rst_ready",      int'(bus.ready), 0);
        end

        // Randomized run against the reference model
        do_reset();
        en_r = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 2999) == 0) en_r = !en_r;
            le_r = ($urandom_range(0, 3) != 0);
            cyc(en_r, le_r);
            model_step(en_r, le_r);
            chk($sformatf("random_cycle%0d", i), dut_vec(),
                pack_vec(m_run, m_cnt, m_vs, model_vde(), m_fs, m_disp, m_bl, m_rdy));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
